// File: rtl/spi_flash_pkg.sv
// Shared command codes, state and data-source types for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_RDSR      = 8'h05;
    localparam logic [7:0] CMD_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

    typedef enum logic [1:0] {
        MEM,
        STATUS,
        ID
    } src_t;

    // Byte idx of the 24-bit identification word, MSB byte first, zero beyond it.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            2'd2:    return id[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchroniser for CSB/SCK/MOSI plus SCK edge detection on the synchronised clock.
module spi_pin_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic csb,
    input  logic sck,
    input  logic mosi,
    output logic csb_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic [2:0] pins;
    logic [2:0] sync_vec;
    logic       sck_prev_reg;

    assign pins = {csb, sck, mosi};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= pins[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_prev_reg <= 1'b0;
        end else begin
            sck_prev_reg <= sync_vec[1];
        end
    end

    assign csb_s    = sync_vec[2];
    assign mosi_s   = sync_vec[0];
    assign sck_rise = sync_vec[1] & ~sck_prev_reg;
    assign sck_fall = ~sync_vec[1] & sck_prev_reg;

endmodule

// File: rtl/spi_flash_responder.sv
// Oversampled mode-0 SPI flash target serving READ/FAST_READ/RDSR/RDID from a synchronous memory port.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter int          MEM_LAT  = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_spi_csb,
    input  logic              i_spi_sck,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oeb,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    output logic              o_busy
);

    // Only the low ADDR_W address bits are kept; the command byte shares the register.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;

    logic csb_s, mosi_s, sck_rise, sck_fall;

    spi_pin_sync u_sync (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .csb      (i_spi_csb),
        .sck      (i_spi_sck),
        .mosi     (i_spi_mosi),
        .csb_s    (csb_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    state_t              state_reg, state_next;
    src_t                src_reg, src_next;
    logic [4:0]          bit_cnt_reg, bit_cnt_next;
    logic [SH_W-2:0]     shift_reg, shift_next;
    logic [SH_W-1:0]     shift_word;
    logic                dummy_reg, dummy_next;
    logic [6:0]          tx_reg, tx_next;
    logic [2:0]          tx_idx_reg, tx_idx_next;
    logic                load_pend_reg, load_pend_next;
    logic [7:0]          hold_reg, hold_next;
    logic [1:0]          id_idx_reg, id_idx_next;
    logic                miso_reg, miso_next;
    logic                oeb_reg, oeb_next;
    logic                mem_rd_reg, mem_rd_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [MEM_LAT-1:0]  rd_pipe_reg, rd_pipe_next;
    logic                busy_reg, busy_next;
    logic                csb_prev_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg     <= IDLE;
            src_reg       <= MEM;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            dummy_reg     <= 1'b0;
            tx_reg        <= '0;
            tx_idx_reg    <= '0;
            load_pend_reg <= 1'b0;
            hold_reg      <= '0;
            id_idx_reg    <= '0;
            miso_reg      <= 1'b0;
            oeb_reg       <= 1'b1;
            mem_rd_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            rd_pipe_reg   <= '0;
            busy_reg      <= 1'b0;
            csb_prev_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            dummy_reg     <= dummy_next;
            tx_reg        <= tx_next;
            tx_idx_reg    <= tx_idx_next;
            load_pend_reg <= load_pend_next;
            hold_reg      <= hold_next;
            id_idx_reg    <= id_idx_next;
            miso_reg      <= miso_next;
            oeb_reg       <= oeb_next;
            mem_rd_reg    <= mem_rd_next;
            mem_addr_reg  <= mem_addr_next;
            rd_pipe_reg   <= rd_pipe_next;
            busy_reg      <= busy_next;
            csb_prev_reg  <= csb_s;
        end
    end

    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        dummy_next     = dummy_reg;
        tx_next        = tx_reg;
        tx_idx_next    = tx_idx_reg;
        load_pend_next = load_pend_reg;
        hold_next      = hold_reg;
        id_idx_next    = id_idx_reg;
        miso_next      = miso_reg;
        oeb_next       = oeb_reg;
        mem_rd_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        rd_pipe_next   = MEM_LAT'({rd_pipe_reg, mem_rd_reg});
        busy_next      = busy_reg;
        shift_word     = {shift_reg, mosi_s};

        // A deasserted CSB overrides any SCK edge seen in the same cycle.
        if (csb_s) begin
            state_next     = IDLE;
            bit_cnt_next   = '0;
            tx_idx_next    = '0;
            load_pend_next = 1'b0;
            oeb_next       = 1'b1;
            miso_next      = 1'b0;
            rd_pipe_next   = '0;
            busy_next      = 1'b0;
        end else begin
            if (rd_pipe_reg[MEM_LAT-1]) begin
                hold_next = i_mem_data;
            end

            case (state_reg)
                IDLE: begin
                    if (csb_prev_reg) begin
                        state_next   = CMD;
                        busy_next    = 1'b1;
                        bit_cnt_next = '0;
                        dummy_next   = 1'b0;
                    end
                end

                CMD: begin
                    if (sck_rise) begin
                        shift_next   = shift_word[SH_W-2:0];
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd7) begin
                            bit_cnt_next   = '0;
                            load_pend_next = 1'b1;
                            case (shift_word[7:0])
                                CMD_READ:      state_next = ADDR;
                                CMD_FAST_READ: begin
                                    state_next = ADDR;
                                    dummy_next = 1'b1;
                                end
                                CMD_RDSR: begin
                                    state_next = DATA;
                                    src_next   = STATUS;
                                    hold_next  = 8'h00;
                                end
                                CMD_RDID: begin
                                    state_next  = DATA;
                                    src_next    = ID;
                                    hold_next   = id_byte(JEDEC_ID, 2'd0);
                                    id_idx_next = 2'd1;
                                end
                                default:       state_next = IGNORE;
                            endcase
                        end
                    end
                end

                ADDR: begin
                    if (sck_rise) begin
                        shift_next   = shift_word[SH_W-2:0];
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd23) begin
                            bit_cnt_next  = '0;
                            mem_rd_next   = 1'b1;
                            mem_addr_next = shift_word[ADDR_W-1:0];
                            src_next      = MEM;
                            state_next    = dummy_reg ? DUMMY : DATA;
                        end
                    end
                end

                DUMMY: begin
                    if (sck_rise) begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd7) begin
                            bit_cnt_next = '0;
                            state_next   = DATA;
                        end
                    end
                end

                DATA: begin
                    if (sck_fall) begin
                        oeb_next = 1'b0;
                        if (load_pend_reg) begin
                            miso_next      = hold_reg[7];
                            tx_next        = hold_reg[6:0];
                            tx_idx_next    = 3'd6;
                            load_pend_next = 1'b0;
                        end else begin
                            miso_next = tx_reg[6];
                            tx_next   = {tx_reg[5:0], 1'b0};
                            if (tx_idx_reg == 3'd0) begin
                                load_pend_next = 1'b1;
                            end else begin
                                tx_idx_next = tx_idx_reg - 3'd1;
                            end
                        end
                    end
                    // The rise sampling bit 0 fetches the next byte well ahead of the loading fall.
                    if (sck_rise) begin
                        bit_cnt_next = (bit_cnt_reg == 5'd7) ? 5'd0 : bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'd7) begin
                            case (src_reg)
                                MEM: begin
                                    mem_rd_next   = 1'b1;
                                    mem_addr_next = mem_addr_reg + ADDR_W'(1);
                                end
                                ID: begin
                                    hold_next = id_byte(JEDEC_ID, id_idx_reg);
                                    if (id_idx_reg != 2'd3) begin
                                        id_idx_next = id_idx_reg + 2'd1;
                                    end
                                end
                                default: hold_next = 8'h00;
                            endcase
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    assign o_spi_miso     = miso_reg;
    assign o_spi_miso_oeb = oeb_reg;
    assign o_mem_rd       = mem_rd_reg;
    assign o_mem_addr     = mem_addr_reg;
    assign o_busy         = busy_reg;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised SPI master with a queue-based scoreboard for spi_flash_responder.
module tb_spi_flash_responder;

    localparam int          ADDR_W = 16;
    localparam logic [23:0] JEDEC  = 24'hEF4016;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        csb = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, oeb, mem_rd, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_byte_q[$];
    logic [15:0] exp_rd_q[$];
    logic        rx_en = 1'b0;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_W   (ADDR_W),
        .JEDEC_ID (JEDEC),
        .MEM_LAT  (1)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_spi_csb      (csb),
        .i_spi_sck      (sck),
        .i_spi_mosi     (mosi),
        .o_spi_miso     (miso),
        .o_spi_miso_oeb (oeb),
        .o_mem_rd       (mem_rd),
        .o_mem_addr     (mem_addr),
        .i_mem_data     (mem_data),
        .o_busy         (busy)
    );

    // Boot memory contents: mem[a] = a[7:0] ^ 0x5A, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[7:0] ^ 8'h5A;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [7:0] cmd, input logic [23:0] addr, input int i);
        logic [15:0] a;
        logic [23:0] jid;
        a   = addr[15:0] + 16'(i);
        jid = JEDEC;
        if (cmd == 8'h03 || cmd == 8'h0B) return a[7:0] ^ 8'h5A;
        if (cmd == 8'h9F && i < 3) return jid[23-8*i -: 8];
        return 8'h00;
    endfunction

    // Memory-read monitor.
    always @(negedge clk) begin
        if (mem_rd) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_rd: got addr %04h required no read", mem_addr);
            end else begin
                check("mem_rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    // MISO monitor: samples like a mode-0 master on every SCK rise.
    initial begin : spi_mon
        int         rx_cnt;
        logic [7:0] rx_byte;
        rx_cnt  = 0;
        rx_byte = 8'h00;
        forever begin
            @(posedge sck);
            if (!rx_en) begin
                rx_cnt = 0;
                check("oeb_not_data", 32'(oeb), 32'd1);
            end else begin
                check("oeb_data", 32'(oeb), 32'd0);
                rx_byte = {rx_byte[6:0], miso};
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_cnt = 0;
                    if (exp_byte_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h required none", rx_byte);
                    end else begin
                        check("miso_byte", 32'(rx_byte), 32'(exp_byte_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic spi_bit(input logic b);
        mosi = b;
        #40;
        sck = 1'b1;
        #40;
        sck = 1'b0;
    endtask

    task automatic end_xfer();
        #40;
        @(posedge clk);
        #1;
        csb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("oeb_after_csb", 32'(oeb), 32'd1);
        check("busy_after_csb", 32'(busy), 32'd0);
        check("pending_bytes", 32'(exp_byte_q.size()), 32'd0);
        check("pending_reads", 32'(exp_rd_q.size()), 32'd0);
        #80;
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int nbits);
        bit is_read, is_data;
        int nbytes;
        is_read = (cmd == 8'h03) || (cmd == 8'h0B);
        is_data = is_read || (cmd == 8'h05) || (cmd == 8'h9F);
        nbytes  = nbits / 8;
        $display("xfer cmd=%02h addr=%06h data_bits=%0d", cmd, addr, nbits);
        if (is_data) for (int i = 0; i < nbytes; i++) exp_byte_q.push_back(ref_byte(cmd, addr, i));
        if (is_read) for (int i = 0; i <= nbytes; i++) exp_rd_q.push_back(addr[15:0] + 16'(i));
        @(posedge clk);
        #2;
        csb = 1'b0;
        #80;
        check("busy_active", 32'(busy), 32'd1);
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i]);
        if (is_read) for (int i = 23; i >= 0; i--) spi_bit(addr[i]);
        if (cmd == 8'h0B) for (int i = 0; i < 8; i++) spi_bit(1'($urandom_range(0, 1)));
        rx_en = is_data;
        for (int i = 0; i < nbits; i++) spi_bit(1'($urandom_range(0, 1)));
        rx_en = 1'b0;
        end_xfer();
    endtask

    task automatic reset_mid_addr(input logic [23:0] addr);
        logic [7:0] cmd;
        cmd = 8'h03;
        $display("xfer cmd=%02h addr=%06h with reset pulse in address phase", cmd, addr);
        @(posedge clk);
        #2;
        csb = 1'b0;
        #80;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i]);
        for (int i = 23; i >= 14; i--) spi_bit(addr[i]);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oeb", 32'(oeb), 32'd1);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        // CSB stays low without a fresh falling edge: the responder must stay silent.
        for (int i = 13; i >= 0; i--) spi_bit(addr[i]);
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom_range(0, 1)));
        check("busy_no_fresh_edge", 32'(busy), 32'd0);
        end_xfer();
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          sel;
        repeat (4) @(posedge clk);
        #1;
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_oeb", 32'(oeb), 32'd1);
        check("reset_mem_rd", 32'(mem_rd), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        xfer(8'h03, 24'h000010, 32);
        xfer(8'h0B, 24'h000100, 16);
        xfer(8'h03, 24'h00FFFF, 16);
        xfer(8'h9F, 24'h000000, 32);
        xfer(8'h05, 24'h000000, 16);
        xfer(8'h66, 24'h000000, 8);
        xfer(8'h03, 24'h000010, 11);
        xfer(8'h03, 24'h000020, 8);
        reset_mid_addr(24'h001234);
        xfer(8'h03, 24'h000030, 16);

        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: cmd = 8'h03;
                1: cmd = 8'h0B;
                2: cmd = 8'h05;
                3: cmd = 8'h9F;
                default: begin
                    cmd = 8'($urandom);
                    if (cmd == 8'h03 || cmd == 8'h0B || cmd == 8'h05 || cmd == 8'h9F) cmd = 8'h66;
                end
            endcase
            addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) addr[15:0] = 16'hFFFD + 16'($urandom_range(0, 2));
            xfer(cmd, addr, int'($urandom_range(8, 40)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
